peak_record_serializer: RTL

Downstream consumer of the matched-filter range detector's peak-record stream. It takes one 512-bit peak record per AXI-Stream transfer and checks its 'PKPK' magic word. It stamps a 16-bit sequence number into the record, buffers up to two records, and emits each record as eight 64-bit AXI-Stream beats for the host/Ethernet path. Backpressure is honoured on both sides; no valid record is ever dropped.

---
 rtl/peak_record_pkg.sv | 32 +++
 rtl/record_fifo2.sv | 42 ++++
 rtl/peak_record_serializer.sv | 133 +++++++++++++
 3 files changed

// File: rtl/peak_record_pkg.sv
// Shared widths, magic word and field layout for the peak-record stream
// and the serializer that turns each record into host-side beats.
package peak_record_pkg;

    localparam int DEFAULT_IN_DATA_WIDTH  = 512;
    localparam int DEFAULT_OUT_DATA_WIDTH = 64;
    localparam int DEFAULT_BEATS          = DEFAULT_IN_DATA_WIDTH / DEFAULT_OUT_DATA_WIDTH;

    localparam logic [31:0] PK_MAGIC = 32'h504b504b;

    localparam int MAGIC_LSB = 0;
    localparam int MAGIC_W   = 32;
    localparam int SEQ_LSB   = 32;
    localparam int SEQ_W     = 16;

    // Record layout, MSB first: peak [511:256], counter_id [127:64],
    // threshold ctrl [63:48], seq/beef [47:32], magic [31:0].
    typedef struct packed {
        logic [255:0] peak;
        logic [127:0] reserved;
        logic [63:0]  counter_id;
        logic [15:0]  threshold_ctrl;
        logic [15:0]  seq;
        logic [31:0]  magic;
    } peak_record_t;

    typedef enum logic {
        ST_IDLE,
        ST_SEND
    } send_state_e;

endpackage

// File: rtl/record_fifo2.sv
// Two-entry record buffer; head_data shows the oldest record whenever
// the buffer is non-empty.
module record_fifo2 #(
    parameter int WIDTH = 512
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    // NOTE: storage is left unreset; the pointers and count alone say which entries hold data.
    always_ff @(posedge aclk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    assign head_data = mem[rd_ptr];
    assign full      = (count == 2'd2);
    assign empty     = (count == 2'd0);

endmodule

// File: rtl/peak_record_serializer.sv
// Checks and sequence-stamps incoming peak records, buffers two of them,
// and replays each as BEATS narrow AXI-Stream beats, beat 0 first.
module peak_record_serializer
    import peak_record_pkg::*;
#(
    parameter int          IN_DATA_WIDTH  = DEFAULT_IN_DATA_WIDTH,
    parameter int          OUT_DATA_WIDTH = DEFAULT_OUT_DATA_WIDTH,
    parameter int          SEQ_INSERT     = 1,
    parameter logic [31:0] MAGIC          = PK_MAGIC
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic [IN_DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic                        s_axis_tvalid,
    input  logic                        s_axis_tlast,
    output logic                        s_axis_tready,
    output logic [OUT_DATA_WIDTH-1:0]   m_axis_tdata,
    output logic                        m_axis_tvalid,
    output logic                        m_axis_tlast,
    output logic [OUT_DATA_WIDTH/8-1:0] m_axis_tkeep,
    input  logic                        m_axis_tready,
    output logic [31:0]                 rec_count,
    output logic [15:0]                 bad_magic_count,
    output logic                        busy
);

    localparam int BEATS = IN_DATA_WIDTH / OUT_DATA_WIDTH;
    localparam int IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEATS - 1);

    send_state_e        state, next_state;
    logic [IDX_W-1:0]   beat_idx, next_idx;
    logic               in_ready;
    logic [SEQ_W-1:0]   seq;
    logic               accept, magic_ok, push, bad, pop;
    logic               beat_hs, last_beat;
    logic [IN_DATA_WIDTH-1:0] stamped, head_data;
    logic               full, empty;
    logic [1:0]         count, next_count;
    logic [BEATS-1:0][OUT_DATA_WIDTH-1:0] beats;
    logic               tlast_unused;

    // Every transfer is a whole record, so the input tlast carries no information.
    assign tlast_unused = s_axis_tlast;

    assign accept   = s_axis_tvalid & in_ready;
    assign magic_ok = (s_axis_tdata[MAGIC_LSB +: MAGIC_W] == MAGIC);
    assign push     = accept & magic_ok;
    assign bad      = accept & ~magic_ok;

    always_comb begin
        stamped = s_axis_tdata;
        if (SEQ_INSERT != 0) stamped[SEQ_LSB +: SEQ_W] = seq;
    end

    record_fifo2 #(.WIDTH(IN_DATA_WIDTH)) u_fifo (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .push      (push),
        .push_data (stamped),
        .pop       (pop),
        .head_data (head_data),
        .full      (full),
        .empty     (empty),
        .count     (count)
    );

    assign beat_hs   = (state == ST_SEND) & m_axis_tready;
    assign last_beat = (beat_idx == LAST_IDX);
    assign pop       = beat_hs & last_beat;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        next_state = state;
        next_idx   = beat_idx;
        case (state)
            ST_IDLE: begin
                if (!empty) begin
                    next_state = ST_SEND;
                    next_idx   = '0;
                end
            end
            ST_SEND: begin
                if (beat_hs) begin
                    if (last_beat) begin
                        next_idx = '0;
                        // A record pushed on the popping edge keeps the stream gap-free.
                        if (!(full || push)) next_state = ST_IDLE;
                    end else begin
                        next_idx = beat_idx + 1'b1;
                    end
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state    <= ST_IDLE;
            beat_idx <= '0;
        end else begin
            state    <= next_state;
            beat_idx <= next_idx;
        end
    end

    // Ready is registered from the post-edge occupancy, so it never sees m_axis_tready combinationally.
    assign next_count = count + {1'b0, push} - {1'b0, pop};

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            in_ready        <= 1'b0;
            seq             <= '0;
            rec_count       <= '0;
            bad_magic_count <= '0;
        end else begin
            in_ready <= (next_count != 2'd2);
            if (push) seq <= seq + 1'b1;
            if (pop)  rec_count <= rec_count + 1'b1;
            if (bad && bad_magic_count != 16'hFFFF) bad_magic_count <= bad_magic_count + 1'b1;
        end
    end

    assign beats         = head_data;
    assign s_axis_tready = in_ready;
    assign m_axis_tvalid = (state == ST_SEND);
    assign m_axis_tdata  = m_axis_tvalid ? beats[beat_idx] : '0;
    assign m_axis_tlast  = m_axis_tvalid & last_beat;
    assign m_axis_tkeep  = {(OUT_DATA_WIDTH/8){m_axis_tvalid}};
    assign busy          = ~empty | m_axis_tvalid;

endmodule
